shift_word_feeder: RTL and testbench

- Parallel-to-serial feeder that sits directly upstream of the team's bidirectional 4-bit shift register.
- Accepts a parallel word plus a direction through a valid/ready handshake.
- Drives the shift register's direction, MSB-serial-in and LSB-serial-in inputs for exactly WIDTH cycles.
- After those cycles the downstream register holds the word unchanged, regardless of shift direction.

---
 rtl/shift_pkg.sv | 14 +
 rtl/feeder_bit_counter.sv | 37 +++
 rtl/shift_word_feeder.sv | 110 +++++++++++
 tb/tb_shift_word_feeder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants and types for the shift-register feeder slice.
package shift_pkg;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam int SHIFT_W = 4;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } feeder_state_t;

endpackage

// File: rtl/feeder_bit_counter.sv
// Bit-position counter for the feeder: clear wins over increment, saturates at WIDTH-1.
// Latency: count and is_last update on the edge after clr/inc; is_last is combinational from the count flop.
module feeder_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic is_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign is_last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !is_last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift_word_feeder.sv
// Serialises a parallel word into a bidirectional shift register; optional word_parity under SHIFT_FEEDER_PARITY_EN.
// Latency: first bit one cycle after accept, WIDTH bit cycles, done on the last; back-to-back accepts have no gap.
// Backpressure: load_ready only in IDLE or the last bit cycle; upstream holds its word while load_ready is low.
module shift_word_feeder
    import shift_pkg::*;
#(
    parameter int   WIDTH    = SHIFT_W,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_dir,
    output logic             ser_dir,
    output logic             ser_msb,
    output logic             ser_lsb,
    output logic             busy,
    output logic             done
`ifdef SHIFT_FEEDER_PARITY_EN
    ,
    output logic             word_parity
`endif
);

    feeder_state_t    state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q, dir_d;
    logic             cnt_clr, cnt_inc, cnt_last;
    logic             last, accept;

    feeder_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .is_last (cnt_last)
    );

    assign last       = (state_q == ST_SHIFT) && cnt_last;
    assign load_ready = (state_q == ST_IDLE) || last;
    assign accept     = load_valid && load_ready;

    assign busy    = (state_q == ST_SHIFT);
    assign done    = last;
    assign ser_dir = dir_q;

    // The unused serial input sees IDLE_BIT so the downstream register never samples stale data.
    assign ser_msb = (busy && dir_q == DIR_RIGHT) ? shreg_q[0]       : IDLE_BIT;
    assign ser_lsb = (busy && dir_q == DIR_LEFT)  ? shreg_q[WIDTH-1] : IDLE_BIT;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dir_d   = dir_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = load_data;
            dir_d   = load_dir;
            cnt_clr = 1'b1;
        end else if (state_q == ST_SHIFT) begin
            shreg_d = (dir_q == DIR_RIGHT) ? (shreg_q >> 1) : (shreg_q << 1);
            if (last) begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end else begin
                cnt_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            dir_q   <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dir_q   <= dir_d;
        end
    end

`ifdef SHIFT_FEEDER_PARITY_EN
    logic parity_q, parity_d;

    assign word_parity = parity_q;

    always_comb begin
        parity_d = parity_q;
        if (accept) begin
            parity_d = ^load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_shift_word_feeder.sv
// Directed bench: drives words into shift_word_feeder and checks serial streams against a downstream register model.
module tb_shift_word_feeder;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_data;
    logic       load_dir;
    logic       ser_dir;
    logic       ser_msb;
    logic       ser_lsb;
    logic       busy;
    logic       done;
`ifdef SHIFT_FEEDER_PARITY_EN
    logic       word_parity;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] ds = 4'b0000;

    shift_word_feeder #(
        .WIDTH    (4),
        .IDLE_BIT (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dir   (load_dir),
        .ser_dir    (ser_dir),
        .ser_msb    (ser_msb),
        .ser_lsb    (ser_lsb),
        .busy       (busy),
        .done       (done)
`ifdef SHIFT_FEEDER_PARITY_EN
        ,
        .word_parity(word_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4-bit bidirectional shift register, shifting while the feeder is busy.
    always @(posedge clk) begin
        if (busy) begin
            ds <= ser_dir ? {ds[2:0], ser_lsb} : {ser_msb, ds[3:1]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input string tag, input logic [3:0] data, input logic dir);
        load_valid = 1'b1;
        load_data  = data;
        load_dir   = dir;
        chk({tag, "_ready"}, 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
    endtask

    // Checks the four bit cycles of one word; returns while still sampling the done cycle.
    task automatic word(input string tag, input logic dir, input logic [3:0] seq, input logic inj);
        for (int i = 0; i < 4; i++) begin
            if (inj && i == 1) begin
                load_valid = 1'b1;
                load_data  = 4'b1111;
                load_dir   = 1'b0;
            end
            chk({tag, "_busy"},  32'(busy),       32'd1);
            chk({tag, "_dir"},   32'(ser_dir),    32'(dir));
            chk({tag, "_ready"}, 32'(load_ready), 32'(i == 3));
            chk({tag, "_done"},  32'(done),       32'(i == 3));
            if (dir == 1'b0) begin
                chk({tag, "_msb"}, 32'(ser_msb), 32'(seq[3-i]));
                chk({tag, "_lsb"}, 32'(ser_lsb), 32'd0);
            end else begin
                chk({tag, "_lsb"}, 32'(ser_lsb), 32'(seq[3-i]));
                chk({tag, "_msb"}, 32'(ser_msb), 32'd0);
            end
            if (i < 3) step();
        end
    endtask

    task automatic idle_chk(input string tag, input logic dir_hold);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_ready"}, 32'(load_ready), 32'd1);
        chk({tag, "_msb"},   32'(ser_msb),    32'd0);
        chk({tag, "_lsb"},   32'(ser_lsb),    32'd0);
        chk({tag, "_dir"},   32'(ser_dir),    32'(dir_hold));
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 4'b0000;
        load_dir   = 1'b0;
        #2;
        idle_chk("reset", 1'b0);
        #2 rst = 1'b0;
        step();

        // Test 1: right shift of 1011, LSB first into MSB
        offer("t1", 4'b1011, 1'b0);
        word("t1", 1'b0, 4'b1101, 1'b0);
        step();
        chk("t1_ds", 32'(ds), 32'hB);
        idle_chk("t1_idle", 1'b0);

        // Test 2: left shift of 1011, MSB first into LSB
        offer("t2", 4'b1011, 1'b1);
        word("t2", 1'b1, 4'b1011, 1'b0);
        step();
        chk("t2_ds", 32'(ds), 32'hB);
        idle_chk("t2_idle", 1'b1);

        // Test 3: back-to-back 0110/right then 1001/left
        load_valid = 1'b1;
        load_data  = 4'b0110;
        load_dir   = 1'b0;
        step();
        word("t3a", 1'b0, 4'b0110, 1'b0);
        load_data = 4'b1001;
        load_dir  = 1'b1;
        step();
        load_valid = 1'b0;
        chk("t3_ds_first", 32'(ds), 32'h6);
        word("t3b", 1'b1, 4'b1001, 1'b0);
        step();
        chk("t3_ds", 32'(ds), 32'h9);
        idle_chk("t3_idle", 1'b1);

        // Test 4: 1111 offered mid-transfer of 0011 waits for the done cycle
        offer("t4", 4'b0011, 1'b0);
        word("t4a", 1'b0, 4'b1100, 1'b1);
        step();
        load_valid = 1'b0;
        chk("t4_ds_first", 32'(ds), 32'h3);
        word("t4b", 1'b0, 4'b1111, 1'b0);
        step();
        chk("t4_ds", 32'(ds), 32'hF);

        // Test 5: asynchronous reset in bit cycle 2 of a left-shift word
        offer("t5", 4'b0101, 1'b1);
        step();
        chk("t5_busy_pre", 32'(busy), 32'd1);
        #3 rst = 1'b1;
        #1;
        idle_chk("t5_rst", 1'b0);
        #1 rst = 1'b0;
        step();
        offer("t5n", 4'b1011, 1'b0);
        word("t5n", 1'b0, 4'b1101, 1'b0);
        step();
        chk("t5_ds", 32'(ds), 32'hB);

`ifdef SHIFT_FEEDER_PARITY_EN
        // Test 6: even parity captured on accept
        chk("t6_par_rst", 32'(word_parity), 32'd0);
        load_valid = 1'b1;
        load_data  = 4'b1011;
        load_dir   = 1'b0;
        step();
        load_valid = 1'b0;
        chk("t6_par_a", 32'(word_parity), 32'd1);
        step(); step(); step();
        chk("t6_par_hold", 32'(word_parity), 32'd1);
        offer("t6b", 4'b0110, 1'b0);
        chk("t6_par_b", 32'(word_parity), 32'd0);
        step(); step(); step(); step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
